// File: rtl/coord_neighbor_gen.sv
// Raster scan of a block that emits four neighbour requests per position
// (orig/inc mux selects) with saturated signed coordinates and valid/ready flow control.
module coord_neighbor_gen #(
  parameter int COORD_W = 8,
  parameter int SIZE_W  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic signed [COORD_W-1:0] X_BASE,
  input  logic signed [COORD_W-1:0] Y_BASE,
  input  logic        [SIZE_W-1:0]  BLK_W,
  input  logic        [SIZE_W-1:0]  BLK_H,
  input  logic                      READY,
  output logic signed [COORD_W-1:0] X_ORIG,
  output logic signed [COORD_W-1:0] X_INC,
  output logic signed [COORD_W-1:0] Y_ORIG,
  output logic signed [COORD_W-1:0] Y_INC,
  output logic                      SEL_X,
  output logic                      SEL_Y,
  output logic                      VALID,
  output logic                      BUSY,
  output logic                      DONE
);

  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  localparam logic signed [COORD_W:0] SAT_MAX = {2'b00, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W:0] SAT_MIN = {2'b11, {(COORD_W-1){1'b0}}};
  localparam logic signed [COORD_W:0] ONE     = {{COORD_W{1'b0}}, 1'b1};

  function automatic logic signed [COORD_W-1:0] sat(input logic signed [COORD_W:0] v);
    if (v > SAT_MAX)      return SAT_MAX[COORD_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[COORD_W-1:0];
    else                  return v[COORD_W-1:0];
  endfunction

  function automatic logic signed [COORD_W:0] sext(input logic signed [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction

  function automatic logic signed [COORD_W:0] zext_off(input logic [SIZE_W-1:0] o);
    return $signed({{(COORD_W+1-SIZE_W){1'b0}}, o});
  endfunction

  state_t                    state_q, state_d;
  logic signed [COORD_W-1:0] xb_q, xb_d, yb_q, yb_d;
  logic        [SIZE_W-1:0]  bw_q, bw_d, bh_q, bh_d;
  logic        [SIZE_W-1:0]  col_q, col_d, row_q, row_d;
  logic        [1:0]         ph_q, ph_d;

  logic signed [COORD_W-1:0] x_orig_d, x_inc_d, y_orig_d, y_inc_d;
  logic                      sel_x_d, sel_y_d, valid_d, busy_d, done_d;
  logic                      hs, last;

  assign hs   = VALID & READY;
  assign last = (ph_q == 2'd3) && (col_q == bw_q) && (row_q == bh_q);

  always_comb begin
    state_d = state_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    bw_d    = bw_q;
    bh_d    = bh_q;
    col_d   = col_q;
    row_d   = row_q;
    ph_d    = ph_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = EMIT;
          xb_d    = X_BASE;
          yb_d    = Y_BASE;
          bw_d    = BLK_W;
          bh_d    = BLK_H;
          col_d   = '0;
          row_d   = '0;
          ph_d    = '0;
        end
      end
      EMIT: begin
        if (hs) begin
          if (last) begin
            state_d = FINISH;
          end else begin
            ph_d = ph_q + 2'd1;
            if (ph_q == 2'd3) begin
              if (col_q == bw_q) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output stage: registered view of the next position so outputs hold while stalled
  always_comb begin
    x_orig_d = X_ORIG;
    x_inc_d  = X_INC;
    y_orig_d = Y_ORIG;
    y_inc_d  = Y_INC;
    sel_x_d  = SEL_X;
    sel_y_d  = SEL_Y;
    valid_d  = (state_d == EMIT);
    busy_d   = (state_d == EMIT);
    done_d   = (state_d == FINISH);
    if (state_d == EMIT) begin
      x_orig_d = sat(sext(xb_d) + zext_off(col_d));
      y_orig_d = sat(sext(yb_d) + zext_off(row_d));
      x_inc_d  = sat(sext(x_orig_d) + ONE);
      y_inc_d  = sat(sext(y_orig_d) + ONE);
      sel_x_d  = ph_d[0];
      sel_y_d  = ph_d[1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ph_q    <= '0;
      X_ORIG  <= '0;
      X_INC   <= '0;
      Y_ORIG  <= '0;
      Y_INC   <= '0;
      SEL_X   <= 1'b0;
      SEL_Y   <= 1'b0;
      VALID   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ph_q    <= ph_d;
      X_ORIG  <= x_orig_d;
      X_INC   <= x_inc_d;
      Y_ORIG  <= y_orig_d;
      Y_INC   <= y_inc_d;
      SEL_X   <= sel_x_d;
      SEL_Y   <= sel_y_d;
      VALID   <= valid_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
    end
  end

  // Latched block parameters carry no reset; they are only observed in EMIT
  always_ff @(posedge CLK) begin
    xb_q <= xb_d;
    yb_q <= yb_d;
    bw_q <= bw_d;
    bh_q <= bh_d;
  end

endmodule

// File: tb/tb_coord_neighbor_gen.sv
// Self-checking bench for coord_neighbor_gen: table of directed scans, hand-written
// reset/START-during-scan sequences and random scans against a queue-based model.
module tb_coord_neighbor_gen;

  logic              CLK = 1'b0;
  logic              RST, START, READY;
  logic signed [7:0] X_BASE, Y_BASE;
  logic        [3:0] BLK_W, BLK_H;
  logic signed [7:0] X_ORIG, X_INC, Y_ORIG, Y_INC;
  logic              SEL_X, SEL_Y, VALID, BUSY, DONE;

  coord_neighbor_gen #(.COORD_W(8), .SIZE_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .X_BASE(X_BASE), .Y_BASE(Y_BASE),
    .BLK_W(BLK_W), .BLK_H(BLK_H), .READY(READY), .X_ORIG(X_ORIG), .X_INC(X_INC),
    .Y_ORIG(Y_ORIG), .Y_INC(Y_INC), .SEL_X(SEL_X), .SEL_Y(SEL_Y), .VALID(VALID),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int xo, xi, yo, yi, sx, sy;
  } nb_t;

  typedef struct {
    int xb, yb, bw, bh, rmode;
    int exp_xo, exp_xi, exp_yo, exp_yi, exp_hs;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Caller is positioned at a falling edge; START is presented for the next rising edge.
  task automatic run_scan(input int xb, input int yb, input int bw, input int bh,
                          input int rmode, input bit poke,
                          output int hs, output nb_t first);
    nb_t exq[$];
    nb_t e;
    int  pat[4] = '{1, 0, 0, 1};
    int  cyc;
    bit  rdy;
    for (int r = 0; r <= bh; r++)
      for (int c = 0; c <= bw; c++)
        for (int p = 0; p < 4; p++) begin
          e.xo = sat8(xb + c);
          e.yo = sat8(yb + r);
          e.xi = sat8(e.xo + 1);
          e.yi = sat8(e.yo + 1);
          e.sx = p % 2;
          e.sy = p / 2;
          exq.push_back(e);
        end
    first = '{0, 0, 0, 0, 0, 0};
    X_BASE = 8'(xb);
    Y_BASE = 8'(yb);
    BLK_W  = 4'(bw);
    BLK_H  = 4'(bh);
    START  = 1'b1;
    READY  = 1'($urandom_range(1));
    @(negedge CLK);
    START = 1'b0;
    if (poke) begin
      X_BASE = 8'($urandom);
      Y_BASE = 8'($urandom);
      BLK_W  = 4'($urandom);
      BLK_H  = 4'($urandom);
    end
    hs  = 0;
    cyc = 0;
    while (!DONE && cyc < 5000) begin
      if (cyc == 0) first = '{int'(X_ORIG), int'(X_INC), int'(Y_ORIG), int'(Y_INC),
                              int'(SEL_X), int'(SEL_Y)};
      chk("valid_in_scan", int'(VALID), 1);
      chk("busy_in_scan", int'(BUSY), 1);
      if (VALID) begin
        if (exq.size() > 0) begin
          e = exq[0];
          chk("x_orig", int'(X_ORIG), e.xo);
          chk("x_inc", int'(X_INC), e.xi);
          chk("y_orig", int'(Y_ORIG), e.yo);
          chk("y_inc", int'(Y_INC), e.yi);
          chk("sel_x", int'(SEL_X), e.sx);
          chk("sel_y", int'(SEL_Y), e.sy);
        end else begin
          chk("extra_valid", 1, 0);
        end
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4] != 0;
        default: rdy = 1'($urandom_range(1));
      endcase
      READY = rdy;
      if (poke && (cyc == 3 || cyc == 4)) begin
        START  = 1'b1;
        X_BASE = 8'sd50;
      end else begin
        START = 1'b0;
      end
      if (VALID && rdy) begin
        hs++;
        if (exq.size() > 0) void'(exq.pop_front());
      end
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    if (!DONE) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("finish_valid", int'(VALID), 0);
      chk("finish_busy", int'(BUSY), 0);
      chk("handshakes", hs, 4 * (bw + 1) * (bh + 1));
      READY = 1'($urandom_range(1));
      @(negedge CLK);
      chk("done_one_cycle", int'(DONE), 0);
      chk("idle_valid", int'(VALID), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x_orig"}, int'(X_ORIG), 0);
    chk({tag, "_x_inc"}, int'(X_INC), 0);
    chk({tag, "_y_orig"}, int'(Y_ORIG), 0);
    chk({tag, "_y_inc"}, int'(Y_INC), 0);
    chk({tag, "_sel"}, int'({SEL_X, SEL_Y}), 0);
    chk({tag, "_valid"}, int'(VALID), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_done"}, int'(DONE), 0);
  endtask

  vec_t vt[7];
  nb_t  fst;
  int   hs;

  initial begin
    vt[0] = '{5, -3, 0, 0, 0,       5, 6, -3, -2, 4};
    vt[1] = '{0, 0, 1, 1, 0,        0, 1, 0, 1, 16};
    vt[2] = '{0, 0, 1, 1, 1,        0, 1, 0, 1, 16};
    vt[3] = '{126, -128, 2, 0, 0,   126, 127, -128, -127, 12};
    vt[4] = '{127, 127, 1, 1, 2,    127, 127, 127, 127, 16};
    vt[5] = '{-128, -1, 3, 2, 2,    -128, -127, -1, 0, 48};
    vt[6] = '{120, 100, 15, 15, 0,  120, 121, 100, 101, 1024};

    RST = 1'b1; START = 1'b0; READY = 1'b0;
    X_BASE = '0; Y_BASE = '0; BLK_W = '0; BLK_H = '0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    START = 1'b1;
    @(negedge CLK);
    chk_zero("reset_over_start");
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    chk("idle_valid", int'(VALID), 0);

    for (int i = 0; i < 7; i++) begin
      run_scan(vt[i].xb, vt[i].yb, vt[i].bw, vt[i].bh, vt[i].rmode, 1'b0, hs, fst);
      chk("tbl_first_xo", fst.xo, vt[i].exp_xo);
      chk("tbl_first_xi", fst.xi, vt[i].exp_xi);
      chk("tbl_first_yo", fst.yo, vt[i].exp_yo);
      chk("tbl_first_yi", fst.yi, vt[i].exp_yi);
      chk("tbl_first_sel", fst.sx + 2 * fst.sy, 0);
      chk("tbl_hs", hs, vt[i].exp_hs);
    end

    // START pulsed mid-scan with a new base must be ignored
    run_scan(10, 20, 1, 1, 0, 1'b1, hs, fst);
    chk("poke_hs", hs, 16);

    // Reset after five handshakes aborts without DONE; START right after reset is accepted
    X_BASE = 8'sd3; Y_BASE = 8'sd4; BLK_W = 4'd1; BLK_H = 4'd1;
    START = 1'b1; READY = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_valid", int'(VALID), 1);
      @(negedge CLK);
    end
    chk("pre_rst_sel", int'({SEL_X, SEL_Y}), 2);
    RST = 1'b1;
    @(negedge CLK);
    chk_zero("midscan_rst");
    RST = 1'b0;
    run_scan(-7, 9, 1, 2, 2, 1'b0, hs, fst);
    chk("post_rst_first_sel", fst.sx + 2 * fst.sy, 0);

    for (int i = 0; i < 8; i++) begin
      run_scan(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               int'($urandom_range(3)), int'($urandom_range(3)), 2,
               1'($urandom_range(1)), hs, fst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/coord_neighbor_gen.md
COORD_NEIGHBOR_GEN -- requirements
Module: coord_neighbor_gen

Interface
REQ-001 SHALL have parameter COORD_W, default 8: signed coordinate width; all coordinate ports use this width.
REQ-002 SHALL have parameter SIZE_W, default 4: width of the block-size inputs.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port START, input, 1: begin a block scan; sampled only in IDLE.
REQ-006 SHALL have port X_BASE, input, COORD_W signed: top-left X of the block.
REQ-007 SHALL have port Y_BASE, input, COORD_W signed: top-left Y of the block.
REQ-008 SHALL have port BLK_W, input, SIZE_W unsigned: block width minus 1.
REQ-009 SHALL have port BLK_H, input, SIZE_W unsigned: block height minus 1.
REQ-010 SHALL have port READY, input, 1: downstream accepts the current output.
REQ-011 SHALL have port X_ORIG, output reg, COORD_W signed: current-position X.
REQ-012 SHALL have port X_INC, output reg, COORD_W signed: saturated X+1.
REQ-013 SHALL have port Y_ORIG, output reg, COORD_W signed: current-position Y.
REQ-014 SHALL have port Y_INC, output reg, COORD_W signed: saturated Y+1.
REQ-015 SHALL have port SEL_X, output reg, 1: X-coordinate mux select; 0 selects orig, 1 selects inc.
REQ-016 SHALL have port SEL_Y, output reg, 1: Y-coordinate mux select; 0 selects orig, 1 selects inc.
REQ-017 SHALL have port VALID, output reg, 1: outputs hold a neighbour request.
REQ-018 SHALL have port BUSY, output reg, 1: scan in progress.
REQ-019 SHALL have port DONE, output reg, 1: one-cycle pulse at scan end.

Function
REQ-020 SHALL implement FSM states IDLE, EMIT, FINISH.
- IDLE -> EMIT on START=1.
- EMIT -> FINISH on the handshake of the last neighbour of the last position.
- FINISH -> IDLE unconditionally after one cycle.
REQ-021 SHALL, on START in IDLE, register X_BASE, Y_BASE, BLK_W and BLK_H, and clear the column offset, row offset and phase counters.
- VALID and BUSY go high on the next cycle (latency 1).
REQ-022 SHALL, for each position, emit four neighbours in phase order 0..3 with (SEL_X,SEL_Y) = (0,0), (1,0), (0,1), (1,1).
REQ-023 SHALL define a handshake as VALID=1 and READY=1 on the same rising edge.
- Handshake advances the phase.
- Without a handshake, all outputs hold stable.
REQ-024 SHALL, after phase 3, wrap the phase to 0 and advance the column.
- After column BLK_W, wrap the column to 0 and advance the row.
- Scan order is raster: X fastest, then Y.
REQ-025 SHALL compute position coordinates as X_ORIG = sat(X_BASE + col) and Y_ORIG = sat(Y_BASE + row).
- Use COORD_W+1-bit intermediates.
- Saturate to [-2^(COORD_W-1), 2^(COORD_W-1)-1], i.e. [-128, 127].
REQ-026 SHALL compute X_INC = sat(X_ORIG + 1) and Y_INC = sat(Y_ORIG + 1), giving X_INC=127 when X_ORIG=127.
REQ-027 SHALL emit exactly 4*(BLK_W+1)*(BLK_H+1) handshakes per scan.
- BLK_W=0 and BLK_H=0 gives a single position (4 handshakes).
REQ-028 SHALL, in FINISH, drive DONE=1, VALID=0 and BUSY=0 for exactly one cycle; DONE is 0 in every other state.
REQ-029 SHALL ignore START while in EMIT or FINISH, and SHALL leave latched base and size values unaffected by input changes during a scan.
REQ-030 SHALL drive VALID=0 in IDLE and FINISH, and SHALL treat READY as don't-care when VALID=0.

Reset
REQ-031 SHALL, with RST=1 at a rising edge, enter IDLE and clear all counters.
- Outputs go to X_ORIG=X_INC=Y_ORIG=Y_INC=0, SEL_X=SEL_Y=0, VALID=BUSY=DONE=0.
REQ-032 SHALL give RST priority over START and handshake.
- RST mid-scan aborts the scan with no DONE pulse.
- START is accepted on the first edge after RST deasserts.

Verification
REQ-033 SHALL cover single position: X_BASE=5, Y_BASE=-3, BLK_W=0, BLK_H=0, READY=1 -> exactly 4 VALID cycles.
- (SEL_X,SEL_Y) sequence 00, 10, 01, 11.
- X_ORIG=5, X_INC=6, Y_ORIG=-3, Y_INC=-2 throughout.
- DONE pulses one cycle after the last handshake.
REQ-034 SHALL cover full scan: BLK_W=1, BLK_H=1, base (0,0), READY=1 -> 16 handshakes.
- Positions in order (0,0), (1,0), (0,1), (1,1).
- BUSY high for 16 cycles, then DONE=1 for one cycle.
REQ-035 SHALL cover backpressure: READY toggling 1,0,0,1 -> outputs frozen while READY=0.
- No phase skipped or repeated; handshake count still 16 for a 2x2 block.
REQ-036 SHALL cover saturation: X_BASE=126, BLK_W=2 -> X_ORIG sequence 126, 127, 127.
- X_INC=127 at columns 1 and 2.
- Y_BASE=-128 -> Y_ORIG=-128, Y_INC=-127.
REQ-037 SHALL cover START during scan: START pulsed mid-scan with new X_BASE=50 -> ignored; the scan completes with the original base.
REQ-038 SHALL cover reset mid-scan: RST asserted after 5 handshakes -> all outputs 0 on the next cycle, no DONE.
- A new START then begins a fresh scan from phase 0.
